// File: rtl/tlb_op_unit.sv
// tlb_op_unit: initiator side of the TLB search/read/write ports.
// Executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB from the MEM stage and
// returns the CSR update values. INVTLB walks every entry once
// (read, compare, write-back with E cleared).
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   cmd_valid/cmd_ready     op handshake (ready only while idle)
//   cmd_op, inv_*           op code and INVTLB operands
//   csr_index/ne/tlbr/entry CSR-side operands, latched on accept
//   tlb_s_*                 search port (vppn/asid out, index/ne in)
//   tlb_r_*                 read port (index out, combinational entry in)
//   tlb_w_*                 write port (strobe, index, entry)
//   done, res_*             one-cycle completion pulse and results
module tlb_op_unit #(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned PIW    = 26,
  parameter int unsigned IW     = $clog2(TLBNUM),
  parameter int unsigned EW     = 37 + 2 * PIW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [4:0]    inv_op,
  input  logic [9:0]    inv_asid,
  input  logic [18:0]   inv_va,
  input  logic [IW-1:0] csr_index,
  input  logic          csr_ne,
  input  logic          csr_tlbr,
  input  logic [EW-1:0] csr_entry,
  output logic [18:0]   tlb_s_vppn,
  output logic [9:0]    tlb_s_asid,
  input  logic [IW-1:0] tlb_s_index,
  input  logic          tlb_s_ne,
  output logic [IW-1:0] tlb_r_index,
  input  logic [EW-1:0] tlb_r_entry,
  output logic          tlb_w_en,
  output logic [IW-1:0] tlb_w_index,
  output logic [EW-1:0] tlb_w_entry,
  output logic          done,
  output logic          res_ne,
  output logic [IW-1:0] res_index,
  output logic [EW-1:0] res_entry,
  output logic          res_ine
);

  // Entry layout {E,G,PS,ASID,VPPN,PI0,PI1}
  localparam int unsigned VPPN_LSB = 2 * PIW;
  localparam int unsigned ASID_LSB = 2 * PIW + 19;
  localparam int unsigned G_BIT    = 2 * PIW + 35;
  localparam int unsigned E_BIT    = 2 * PIW + 36;
  localparam int unsigned CW       = IW + 1;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WALK, ST_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [2:0]      r_op;
  logic [4:0]      r_inv_op;
  logic [9:0]      r_inv_asid;
  logic [18:0]     r_inv_va;
  logic            r_ine;
  logic [18:0]     r_s_vppn;
  logic [9:0]      r_s_asid;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_fill_ptr;
  logic [IW-1:0]   r_r_index;
  logic            r_w_en;
  logic [IW-1:0]   r_w_index;
  logic [EW-1:0]   r_w_entry;
  logic            r_cmd_ready;
  logic            r_done;
  logic            r_res_ne;
  logic [IW-1:0]   r_res_index;
  logic [EW-1:0]   r_res_entry;
  logic            r_res_ine;

  logic            w_accept;
  logic            w_cmd_ine;
  logic            w_is_walk;
  logic            w_finish;
  logic            w_rd_e;
  logic            w_rd_g;
  logic            w_asid_eq;
  logic            w_vppn_eq;
  logic            w_inv_hit;
  logic            w_unused;

  assign w_accept  = cmd_valid & r_cmd_ready;
  assign w_cmd_ine = (cmd_op > OP_INV) || ((cmd_op == OP_INV) && (inv_op > 5'd6));
  assign w_is_walk = (cmd_op == OP_INV) && (inv_op <= 5'd6);
  // Results are captured on the last working cycle before DONE
  assign w_finish  = (r_state == ST_EXEC) || ((r_state == ST_WALK) && r_cnt[IW]);

  // The E bit of csr_entry is not used; written E comes from csr_ne/csr_tlbr
  assign w_unused  = csr_entry[E_BIT];

  // Walk compare on the entry currently being read
  assign w_rd_e    = tlb_r_entry[E_BIT];
  assign w_rd_g    = tlb_r_entry[G_BIT];
  assign w_asid_eq = (tlb_r_entry[ASID_LSB +: 10] == r_inv_asid);
  assign w_vppn_eq = (tlb_r_entry[VPPN_LSB +: 19] == r_inv_va);

  always_comb begin
    w_inv_hit = 1'b0;
    case (r_inv_op)
      5'd0, 5'd1: w_inv_hit = 1'b1;
      5'd2:       w_inv_hit = w_rd_g;
      5'd3:       w_inv_hit = ~w_rd_g;
      5'd4:       w_inv_hit = ~w_rd_g & w_asid_eq;
      5'd5:       w_inv_hit = ~w_rd_g & w_asid_eq & w_vppn_eq;
      5'd6:       w_inv_hit = (w_rd_g | w_asid_eq) & w_vppn_eq;
      default:    w_inv_hit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; the walk spends one extra cycle draining its last write
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_is_walk ? ST_WALK : ST_EXEC;
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_WALK: if (r_cnt[IW]) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latches, TLB port registers and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= '0;
      r_inv_op    <= '0;
      r_inv_asid  <= '0;
      r_inv_va    <= '0;
      r_ine       <= 1'b0;
      r_s_vppn    <= '0;
      r_s_asid    <= '0;
      r_cnt       <= '0;
      r_fill_ptr  <= '0;
      r_r_index   <= '0;
      r_w_en      <= 1'b0;
      r_w_index   <= '0;
      r_w_entry   <= '0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_res_ne    <= 1'b0;
      r_res_index <= '0;
      r_res_entry <= '0;
      r_res_ine   <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_w_en      <= 1'b0;

      if (w_accept) begin
        r_op       <= cmd_op;
        r_inv_op   <= inv_op;
        r_inv_asid <= inv_asid;
        r_inv_va   <= inv_va;
        r_ine      <= w_cmd_ine;
        r_s_vppn   <= csr_entry[VPPN_LSB +: 19];
        r_s_asid   <= csr_entry[ASID_LSB +: 10];
        r_cnt      <= '0;
        r_r_index  <= w_is_walk ? '0 : csr_index;
        // WR/FILL strobe is registered here so it lands in the EXEC cycle
        if ((cmd_op == OP_WR) || (cmd_op == OP_FILL)) begin
          r_w_en    <= 1'b1;
          r_w_index <= (cmd_op == OP_FILL) ? r_fill_ptr : csr_index;
          r_w_entry <= {csr_tlbr | ~csr_ne, csr_entry[EW-2:0]};
        end
        if (cmd_op == OP_FILL) r_fill_ptr <= r_fill_ptr + IW'(1);
      end

      // Walk: read entry idx, write it back one cycle later if it matches
      if ((r_state == ST_WALK) && !r_cnt[IW]) begin
        r_cnt     <= r_cnt + CW'(1);
        r_r_index <= r_r_index + IW'(1);
        if (w_inv_hit && w_rd_e) begin
          r_w_en    <= 1'b1;
          r_w_index <= r_r_index;
          r_w_entry <= {1'b0, tlb_r_entry[EW-2:0]};
        end
      end

      if (w_finish) begin
        r_res_ine   <= r_ine;
        r_res_ne    <= (r_op == OP_SRCH) ? tlb_s_ne :
                       (r_op == OP_RD)   ? ~tlb_r_entry[E_BIT] : 1'b0;
        r_res_index <= (r_op == OP_SRCH) ? tlb_s_index : '0;
        r_res_entry <= (r_op == OP_RD)   ? tlb_r_entry : '0;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign tlb_s_vppn  = r_s_vppn;
  assign tlb_s_asid  = r_s_asid;
  assign tlb_r_index = r_r_index;
  assign tlb_w_en    = r_w_en;
  assign tlb_w_index = r_w_index;
  assign tlb_w_entry = r_w_entry;
  assign done        = r_done;
  assign res_ne      = r_res_ne;
  assign res_index   = r_res_index;
  assign res_entry   = r_res_entry;
  assign res_ine     = r_res_ine;

endmodule

// File: tb/tb_tlb_op_unit.sv
// tb_tlb_op_unit: bench for tlb_op_unit with a TLB array model on the port
// side, a rule-based reference model and a scoreboard (expected completions
// and expected writes) checked by a separate monitor.
module tb_tlb_op_unit;

  localparam int unsigned TLBNUM   = 16;
  localparam int unsigned PIW      = 26;
  localparam int unsigned IW       = 4;
  localparam int unsigned EW       = 37 + 2 * PIW;
  localparam int unsigned VPPN_LSB = 2 * PIW;
  localparam int unsigned ASID_LSB = 2 * PIW + 19;
  localparam int unsigned G_BIT    = 2 * PIW + 35;
  localparam int unsigned E_BIT    = 2 * PIW + 36;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [4:0]    inv_op;
  logic [9:0]    inv_asid;
  logic [18:0]   inv_va;
  logic [IW-1:0] csr_index;
  logic          csr_ne;
  logic          csr_tlbr;
  logic [EW-1:0] csr_entry;
  logic [18:0]   tlb_s_vppn;
  logic [9:0]    tlb_s_asid;
  logic [IW-1:0] tlb_s_index;
  logic          tlb_s_ne;
  logic [IW-1:0] tlb_r_index;
  logic [EW-1:0] tlb_r_entry;
  logic          tlb_w_en;
  logic [IW-1:0] tlb_w_index;
  logic [EW-1:0] tlb_w_entry;
  logic          done;
  logic          res_ne;
  logic [IW-1:0] res_index;
  logic [EW-1:0] res_entry;
  logic          res_ine;

  tlb_op_unit #(.TLBNUM(TLBNUM), .PIW(PIW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
    .csr_index(csr_index), .csr_ne(csr_ne), .csr_tlbr(csr_tlbr), .csr_entry(csr_entry),
    .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid), .tlb_s_index(tlb_s_index),
    .tlb_s_ne(tlb_s_ne), .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .tlb_w_en(tlb_w_en), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
    .done(done), .res_ne(res_ne), .res_index(res_index), .res_entry(res_entry),
    .res_ine(res_ine)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TLB array on the far side of the ports
  logic [EW-1:0] tlb_mem [TLBNUM];
  logic          mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < TLBNUM; i++) tlb_mem[i] <= '0;
    end else if (tlb_w_en) begin
      tlb_mem[tlb_w_index] <= tlb_w_entry;
    end
  end

  always_comb begin
    tlb_r_entry = tlb_mem[tlb_r_index];
    tlb_s_ne    = 1'b1;
    tlb_s_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (tlb_mem[i][E_BIT] && (tlb_mem[i][VPPN_LSB +: 19] == tlb_s_vppn) &&
          (tlb_mem[i][G_BIT] || (tlb_mem[i][ASID_LSB +: 10] == tlb_s_asid))) begin
        tlb_s_ne    = 1'b0;
        tlb_s_index = IW'(i);
      end
    end
  end

  // Reference model and scoreboard
  typedef struct {
    int unsigned   cyc;
    logic          ine;
    logic          chk_ne;
    logic          ne;
    logic          chk_idx;
    logic [IW-1:0] idx;
    logic          chk_ent;
    logic [EW-1:0] ent;
  } exp_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic [EW-1:0] ent;
  } wr_t;

  exp_t          exp_q [$];
  wr_t           wr_q  [$];
  logic [EW-1:0] ref_mem [TLBNUM];
  logic [EW-1:0] snap    [TLBNUM];
  int unsigned   ref_fill;
  int unsigned   n_vec;
  int unsigned   n_err;

  task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [EW-1:0] mk_entry(input logic g, input logic [9:0] a, input logic [18:0] v);
    logic [EW-1:0] e;
    e = EW'({$urandom(), $urandom(), $urandom()});
    e[G_BIT] = g;
    e[ASID_LSB +: 10] = a;
    e[VPPN_LSB +: 19] = v;
    return e;
  endfunction

  function automatic logic [18:0] pick_vppn();
    case ($urandom_range(0, 2))
      0:       return 19'h12345;
      1:       return 19'h00abc;
      default: return 19'h7ffff;
    endcase
  endfunction

  function automatic logic [EW-1:0] rand_entry();
    return mk_entry(1'($urandom_range(0, 1)), 10'(3 + $urandom_range(0, 2)), pick_vppn());
  endfunction

  // Lowest-numbered valid entry matching VPPN and (global or same ASID); -1 on miss
  function automatic int ref_search(input logic [18:0] v, input logic [9:0] a);
    for (int i = 0; i < TLBNUM; i++)
      if (ref_mem[i][E_BIT] && ref_mem[i][VPPN_LSB +: 19] == v &&
          (ref_mem[i][G_BIT] || ref_mem[i][ASID_LSB +: 10] == a)) return i;
    return -1;
  endfunction

  function automatic logic inv_match(input logic [4:0] op, input logic [EW-1:0] e,
                                     input logic [9:0] a, input logic [18:0] va);
    logic g, am, vm;
    g  = e[G_BIT];
    am = (e[ASID_LSB +: 10] == a);
    vm = (e[VPPN_LSB +: 19] == va);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return g;
      5'd3:       return !g;
      5'd4:       return !g && am;
      5'd5:       return !g && am && vm;
      5'd6:       return (g || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  // Wait for ready, record what the op must produce, then present it for one cycle
  task automatic issue(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] ia,
                       input logic [18:0] iva, input logic [IW-1:0] idx, input logic ne,
                       input logic tlbr, input logic [EW-1:0] ent);
    exp_t          e;
    wr_t           w;
    int            hit;
    int unsigned   n;
    logic          legal;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail("ready_timeout");
      return;
    end
    legal     = (op <= 3'd4) && !(op == 3'd4 && iop > 5'd6);
    e.cyc     = cyc + 1 + ((op == 3'd4 && legal) ? TLBNUM + 2 : 2);
    e.ine     = !legal;
    e.chk_ne  = 1'b0;
    e.ne      = 1'b0;
    e.chk_idx = 1'b0;
    e.idx     = '0;
    e.chk_ent = 1'b0;
    e.ent     = '0;
    case (op)
      3'd0: begin
        hit = ref_search(ent[VPPN_LSB +: 19], ent[ASID_LSB +: 10]);
        e.chk_ne = 1'b1;
        e.ne     = (hit < 0);
        if (hit >= 0) begin
          e.chk_idx = 1'b1;
          e.idx     = IW'(hit);
        end
      end
      3'd1: begin
        e.chk_ne = 1'b1;
        e.ne     = !ref_mem[idx][E_BIT];
        if (!e.ne) begin
          e.chk_ent = 1'b1;
          e.ent     = ref_mem[idx];
        end
      end
      3'd2, 3'd3: begin
        w.ent = ent;
        w.ent[E_BIT] = tlbr ? 1'b1 : !ne;
        if (op == 3'd3) begin
          w.idx    = IW'(ref_fill);
          ref_fill = (ref_fill + 1) % TLBNUM;
        end else begin
          w.idx = idx;
        end
        ref_mem[w.idx] = w.ent;
        wr_q.push_back(w);
      end
      3'd4: begin
        if (legal) begin
          for (int i = 0; i < TLBNUM; i++) begin
            if (ref_mem[i][E_BIT] && inv_match(iop, ref_mem[i], ia, iva)) begin
              ref_mem[i][E_BIT] = 1'b0;
              w.idx = IW'(i);
              w.ent = ref_mem[i];
              wr_q.push_back(w);
            end
          end
        end
      end
      default: ;
    endcase
    exp_q.push_back(e);
    cmd_op    = op;
    inv_op    = iop;
    inv_asid  = ia;
    inv_va    = iva;
    csr_index = idx;
    csr_ne    = ne;
    csr_tlbr  = tlbr;
    csr_entry = ent;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    // Scramble operands so only latched copies can be correct
    cmd_op    = 3'($urandom);
    inv_op    = 5'($urandom);
    inv_asid  = 10'($urandom);
    inv_va    = 19'($urandom);
    csr_index = IW'($urandom);
    csr_ne    = 1'($urandom);
    csr_tlbr  = 1'($urandom);
    csr_entry = rand_entry();
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
  endtask

  task automatic monitor();
    exp_t e;
    wr_t  w;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
        continue;
      end
      if (done) begin
        chk("done_back_to_back", EW'(prev_done), EW'(0));
        if (exp_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", EW'(cyc + 1), EW'(e.cyc));
          chk("res_ine", EW'(res_ine), EW'(e.ine));
          if (e.chk_ne)  chk("res_ne", EW'(res_ne), EW'(e.ne));
          if (e.chk_idx) chk("res_index", EW'(res_index), EW'(e.idx));
          if (e.chk_ent) chk("res_entry", res_entry, e.ent);
        end
      end
      if (tlb_w_en) begin
        if (wr_q.size() == 0) begin
          fail("unexpected_write");
        end else begin
          w = wr_q.pop_front();
          chk("w_index", EW'(tlb_w_index), EW'(w.idx));
          chk("w_entry", tlb_w_entry, w.ent);
        end
      end
      prev_done = done;
    end
  endtask

  initial begin
    logic [EW-1:0] ent;
    logic [2:0]    op;
    int unsigned   n;
    n_vec = 0;
    n_err = 0;
    ref_fill = 0;
    for (int i = 0; i < TLBNUM; i++) ref_mem[i] = '0;
    reset = 1'b1;
    mem_clr = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    inv_op = '0;
    inv_asid = '0;
    inv_va = '0;
    csr_index = '0;
    csr_ne = 1'b0;
    csr_tlbr = 1'b0;
    csr_entry = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", EW'(cmd_ready), EW'(1));
    chk("rst_done", EW'(done), EW'(0));
    chk("rst_w_en", EW'(tlb_w_en), EW'(0));
    chk("rst_res_ne", EW'(res_ne), EW'(0));
    chk("rst_res_index", EW'(res_index), EW'(0));
    chk("rst_res_entry", res_entry, EW'(0));
    chk("rst_res_ine", EW'(res_ine), EW'(0));
    reset = 1'b0;
    mem_clr = 1'b0;
    fork
      monitor();
    join_none

    // Write then search hit / search miss on ASID
    ent = mk_entry(1'b0, 10'd3, 19'h12345);
    issue(3'd2, 5'd0, 10'd0, 19'd0, IW'(5), 1'b0, 1'b0, ent);
    issue(3'd0, 5'd0, 10'd0, 19'd0, IW'(0), 1'b0, 1'b0, ent);
    ent[ASID_LSB +: 10] = 10'd4;
    issue(3'd0, 5'd0, 10'd0, 19'd0, IW'(0), 1'b0, 1'b0, ent);

    // Refill write forces E=1 despite NE; read it back
    ent = rand_entry();
    issue(3'd2, 5'd0, 10'd0, 19'd0, IW'(2), 1'b1, 1'b1, ent);
    issue(3'd1, 5'd0, 10'd0, 19'd0, IW'(2), 1'b0, 1'b0, rand_entry());
    issue(3'd1, 5'd0, 10'd0, 19'd0, IW'(9), 1'b0, 1'b0, rand_entry());

    // 17 fills wrap the fill pointer
    for (int i = 0; i < 17; i++)
      issue(3'd3, 5'd0, 10'd0, 19'd0, IW'($urandom), 1'($urandom), 1'($urandom), rand_entry());

    // Selective invalidate: non-global ASID 3 entry goes, global one stays
    issue(3'd2, 5'd0, 10'd0, 19'd0, IW'(5), 1'b0, 1'b0, mk_entry(1'b0, 10'd3, 19'h12345));
    issue(3'd2, 5'd0, 10'd0, 19'd0, IW'(7), 1'b0, 1'b0, mk_entry(1'b1, 10'd3, 19'h12345));
    issue(3'd4, 5'd5, 10'd3, 19'h12345, IW'(0), 1'b0, 1'b0, rand_entry());
    issue(3'd1, 5'd0, 10'd0, 19'd0, IW'(7), 1'b0, 1'b0, rand_entry());

    // Illegal codes
    issue(3'd4, 5'd7, 10'd3, 19'h12345, IW'(0), 1'b0, 1'b0, rand_entry());
    issue(3'd6, 5'd0, 10'd0, 19'd0, IW'(3), 1'b0, 1'b0, rand_entry());
    issue(3'd4, 5'd31, 10'd4, 19'h00abc, IW'(0), 1'b0, 1'b0, rand_entry());

    // Randomized mix
    for (int k = 0; k < 150; k++) begin
      n = $urandom_range(0, 9);
      case (n)
        0, 1:    op = 3'd0;
        2, 3:    op = 3'd1;
        4, 5:    op = 3'd2;
        6:       op = 3'd3;
        7, 8:    op = 3'd4;
        default: op = 3'(5 + $urandom_range(0, 2));
      endcase
      issue(op, (n == 8) ? 5'(7 + $urandom_range(0, 24)) : 5'($urandom_range(0, 6)),
            10'(3 + $urandom_range(0, 2)), pick_vppn(), IW'($urandom),
            1'($urandom), 1'($urandom), rand_entry());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    for (int i = 0; i < TLBNUM; i++) chk("mem_after_random", tlb_mem[i], ref_mem[i]);

    // Reset in the middle of an invalidate-all walk
    for (int i = 0; i < TLBNUM; i++)
      issue(3'd3, 5'd0, 10'd0, 19'd0, IW'(0), 1'b0, 1'b0, rand_entry());
    drain();
    for (int i = 0; i < TLBNUM; i++) snap[i] = ref_mem[i];
    issue(3'd4, 5'd1, 10'd0, 19'd0, IW'(0), 1'b0, 1'b0, rand_entry());
    n = 0;
    while (!(tlb_r_index == IW'(8) && !cmd_ready && !done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("walk_idx8_timeout");
    reset = 1'b1;
    #1;
    chk("abort_w_en", EW'(tlb_w_en), EW'(0));
    chk("abort_cmd_ready", EW'(cmd_ready), EW'(1));
    chk("abort_done", EW'(done), EW'(0));
    exp_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 8; i < TLBNUM; i++) chk("abort_untouched", tlb_mem[i], snap[i]);
    for (int i = 0; i < 7; i++) chk("abort_cleared_e", EW'(tlb_mem[i][E_BIT]), EW'(0));
    // Entry 7 may or may not have been written when reset hit; adopt the array state
    for (int i = 0; i < TLBNUM; i++) ref_mem[i] = tlb_mem[i];
    ref_fill = 0;
    issue(3'd3, 5'd0, 10'd0, 19'd0, IW'(9), 1'b0, 1'b0, rand_entry());
    issue(3'd1, 5'd0, 10'd0, 19'd0, IW'(0), 1'b0, 1'b0, rand_entry());
    drain();
    repeat (3) @(negedge clk);
    if (wr_q.size() != 0) fail("writes_missing");
    for (int i = 0; i < TLBNUM; i++) chk("mem_final", tlb_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
